// File: rtl/corr_frame_seq.sv
// Frame sequencer: assembles 20-sample frames in a ping-pong buffer and drives one correlator pass per frame.
// Optional peak |result| tracker is built when CORR_FRAME_SEQ_PEAK_EN is defined.
module corr_frame_seq #(
    parameter int unsigned FRAME_LEN = 20,
    parameter logic [4:0]  IDLE_TIM  = 5'd31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [4:0]        corr_tim,
    output logic signed [7:0] corr_sig,
    input  logic signed [9:0] corr_con,
    input  logic              corr_rdy,
    output logic signed [9:0] res_data,
    output logic              res_valid,
    input  logic              res_ack,
    output logic              busy,
    output logic              err
`ifdef CORR_FRAME_SEQ_PEAK_EN
    ,
    output logic [9:0]        peak_mag,
    input  logic              peak_clr
`endif
);

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned RES_W    = 10;
    localparam int unsigned TIM_W    = 5;
    localparam logic [TIM_W-1:0] LAST_IDX = TIM_W'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [SAMPLE_W-1:0] frame_q [2][FRAME_LEN];
    logic [1:0]         full_q;
    logic [1:0]         full_d;
    logic               wr_bank_q;
    logic               rd_bank_q;
    logic [TIM_W-1:0]   wr_idx_q;
    logic [TIM_W-1:0]   tim_q;
    logic [RES_W-1:0]   res_data_q;
    logic               res_valid_q;
    logic               err_q;

    logic accept;
    logic last_wr;
    logic run_last;
    logic capture;

    assign in_ready  = ~full_q[wr_bank_q];
    assign accept    = in_valid & in_ready;
    assign last_wr   = accept & (wr_idx_q == LAST_IDX);
    assign run_last  = (state_q == S_RUN) & (tim_q == LAST_IDX);
    assign capture   = run_last & corr_rdy;

    assign corr_tim  = tim_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q == S_RUN);
    assign err       = err_q;

    // Sample storage; partial frames are discarded through the index/full flags, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_q[wr_bank_q][wr_idx_q] <= in_data;
        end
    end

    // Combinational read of the active bank while a pass is running.
    always_comb begin
        corr_sig = '0;
        if (state_q == S_RUN) begin
            corr_sig = frame_q[rd_bank_q][tim_q];
        end
    end

    // A bank fill and a pass release always target opposite banks, so both apply.
    always_comb begin
        full_d = full_q;
        if (last_wr) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (run_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Write pointer, read FSM, result port and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            tim_q       <= IDLE_TIM;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            full_q <= full_d;

            if (accept) begin
                if (wr_idx_q == LAST_IDX) begin
                    wr_idx_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_idx_q <= wr_idx_q + TIM_W'(1);
                end
            end

            if (res_valid_q && res_ack) begin
                res_valid_q <= 1'b0;
            end

            if ((corr_rdy && !run_last) || (run_last && !corr_rdy)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (full_q[rd_bank_q] && !res_valid_q) begin
                        state_q <= S_RUN;
                        tim_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (tim_q == LAST_IDX) begin
                        if (corr_rdy) begin
                            res_data_q  <= corr_con;
                            res_valid_q <= 1'b1;
                        end
                        rd_bank_q <= ~rd_bank_q;
                        tim_q     <= IDLE_TIM;
                        state_q   <= S_IDLE;
                    end else begin
                        tim_q <= tim_q + TIM_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tim_q   <= IDLE_TIM;
                end
            endcase
        end
    end

`ifdef CORR_FRAME_SEQ_PEAK_EN
    logic [RES_W-1:0] con_bits;
    logic [RES_W-1:0] con_mag;
    logic [RES_W-1:0] peak_q;

    // Two's-complement magnitude; -512 maps to 512, which still fits the unsigned 10-bit field.
    assign con_bits = corr_con;
    assign con_mag  = con_bits[RES_W-1] ? (~con_bits + RES_W'(1)) : con_bits;
    assign peak_mag = peak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else if (peak_clr) begin
            peak_q <= '0;
        end else if (capture && (con_mag > peak_q)) begin
            peak_q <= con_mag;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_corr_frame_seq.sv
// Bench for corr_frame_seq: a position-weighted checksum correlator stub plus a frame-level scoreboard.
module tb_corr_frame_seq;

    logic              clk;
    logic              rst;
    logic signed [7:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        corr_tim;
    logic signed [7:0] corr_sig;
    logic signed [9:0] corr_con;
    logic              corr_rdy;
    logic signed [9:0] res_data;
    logic              res_valid;
    logic              res_ack;
    logic              busy;
    logic              err;
`ifdef CORR_FRAME_SEQ_PEAK_EN
    logic [9:0]        peak_mag;
    logic              peak_clr;
`endif

    corr_frame_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .corr_tim  (corr_tim),
        .corr_sig  (corr_sig),
        .corr_con  (corr_con),
        .corr_rdy  (corr_rdy),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ack   (res_ack),
        .busy      (busy),
        .err       (err)
`ifdef CORR_FRAME_SEQ_PEAK_EN
        ,
        .peak_mag  (peak_mag),
        .peak_clr  (peak_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Correlator stand-in: result = sum over the pass of (tim+1)*sample, wrapped to 10 bits.
    int   stub_acc;
    logic suppress_rdy;
    logic spurious_rdy;
    always @(posedge clk or posedge rst) begin
        if (rst) stub_acc <= 0;
        else if (corr_tim == 5'd0) stub_acc <= int'(corr_sig);
        else if (corr_tim < 5'd20) stub_acc <= stub_acc + (int'(corr_tim) + 1) * int'(corr_sig);
    end
    assign corr_con = 10'(stub_acc + 20 * int'(corr_sig));
    assign corr_rdy = ((corr_tim == 5'd19) && !suppress_rdy) || spurious_rdy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_res = 0;
    int last_acc_cyc = 0;
    int pk = 0;
    logic feed_en;
    logic rand_mode;
    logic signed [7:0] src[$];
    logic signed [7:0] frame[$];
    logic [9:0]        exp_q[$];
    int sine[20] = '{0, 39, 75, 103, 121, 127, 121, 103, 75, 39,
                     0, -39, -75, -103, -121, -127, -121, -103, -75, -39};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ref_result(input logic signed [7:0] f[$]);
        int s = 0;
        for (int i = 0; i < 20; i++) s += (i + 1) * int'(f[i]);
        return 10'(s);
    endfunction

    // One clock: sample handshakes before the edge, update the model, drive new inputs on the falling edge.
    task automatic step();
        logic              acc_now;
        logic              took;
        logic [9:0]        rd;
        logic [9:0]        e;
        logic signed [7:0] d;
        int                v;
`ifdef CORR_FRAME_SEQ_PEAK_EN
        logic [9:0]        pm;
        pm = peak_mag;
`endif
        acc_now = in_valid && in_ready;
        took    = res_valid && res_ack;
        rd      = res_data;
        d       = in_data;
        @(posedge clk);
        cyc++;
        if (acc_now) begin
            void'(src.pop_front());
            frame.push_back(d);
            n_acc++;
            last_acc_cyc = cyc;
            if (frame.size() == 20) begin
                exp_q.push_back(ref_result(frame));
                frame.delete();
            end
        end
        if (took) begin
            n_res++;
            if (exp_q.size() == 0) begin
                chk("res_unexpected", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("res_data", 32'(rd), 32'(e));
                v = int'(signed'(e));
                if (v < 0) v = -v;
                if (v > pk) pk = v;
`ifdef CORR_FRAME_SEQ_PEAK_EN
                chk("peak_mag", 32'(pm), 32'(pk));
`endif
            end
        end
        @(negedge clk);
        if (rand_mode) begin
            feed_en = ($urandom_range(0, 3) != 0);
            res_ack = ($urandom_range(0, 1) == 1);
        end
        in_valid = feed_en && (src.size() > 0);
        in_data  = in_valid ? src[0] : 8'sd0;
    endtask

    task automatic run_until_acc(input int target, input int bound);
        int k = 0;
        while (n_acc < target && k < bound) begin step(); k++; end
        chk("accept_timeout", 32'(n_acc >= target), 1);
    endtask

    task automatic wait_res(input string tag, input int bound);
        int k = 0;
        while (!res_valid && k < bound) begin step(); k++; end
        chk(tag, 32'(res_valid), 1);
    endtask

    task automatic drain(input string tag, input int bound);
        int k = 0;
        res_ack = 1'b1;
        while ((src.size() > 0 || exp_q.size() > 0 || res_valid) && k < bound) begin step(); k++; end
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_corr_tim"}, 32'(corr_tim), 31);
        chk({tag, "_corr_sig"}, 32'(corr_sig), 0);
        chk({tag, "_res_data"}, 32'(res_data), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), 0);
`ifdef CORR_FRAME_SEQ_PEAK_EN
        chk({tag, "_peak_mag"}, 32'(peak_mag), 0);
`endif
    endtask

    task automatic push_frame_rand();
        for (int i = 0; i < 20; i++) src.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int base;
        int e;
        int lat;
        int k;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ack = 1'b0;
        suppress_rdy = 1'b0; spurious_rdy = 1'b0; feed_en = 1'b1; rand_mode = 1'b0;
`ifdef CORR_FRAME_SEQ_PEAK_EN
        peak_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        // DC frame with ack held high: latency, pass start and single-cycle result pulse.
        res_ack = 1'b1;
        for (int i = 0; i < 20; i++) src.push_back(8'sd64);
        step();
        run_until_acc(20, 40);
        e = last_acc_cyc;
        step();
        chk("dc_run_tim0", 32'(corr_tim), 0);
        chk("dc_busy", 32'(busy), 1);
        wait_res("dc_res_timeout", 40);
        chk("dc_latency", 32'(cyc - e), 21);
        step();
        chk("dc_pulse", 32'(res_valid), 0);

        // Matched sine, negated sine, and a frame whose result is -512.
        for (int i = 0; i < 20; i++) src.push_back(8'(sine[i]));
        for (int i = 0; i < 20; i++) src.push_back(8'(-sine[i]));
        for (int i = 0; i < 20; i++) src.push_back((i == 15) ? 8'sd32 : 8'sd0);
        base = n_res;
        drain("sine_drain", 200);
        chk("sine_count", 32'(n_res - base), 3);

        // Randomized data, valid gaps and ack timing.
        rand_mode = 1'b1;
        for (int f = 0; f < 4; f++) push_frame_rand();
        base = n_res;
        k = 0;
        while ((src.size() > 0 || exp_q.size() > 0) && k < 1000) begin step(); k++; end
        rand_mode = 1'b0; feed_en = 1'b1;
        drain("rand_drain", 100);
        chk("rand_count", 32'(n_res - base), 4);

        // Backpressure: three frames streamed with ack low.
        res_ack = 1'b0;
        for (int f = 0; f < 3; f++) push_frame_rand();
        base = n_acc;
        run_until_acc(base + 40, 100);
        chk("bp_stall_at_40", 32'(in_ready), 0);
        repeat (60) step();
        chk("bp_accepted", 32'(n_acc - base), 60);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_res_held", 32'(res_valid), 1);
        res_ack = 1'b1;
        step();
        e = cyc;
        res_ack = 1'b0;
        wait_res("bp_next_timeout", 40);
        lat = cyc - e;
        chk("bp_ack_to_next", 32'(lat >= 21 && lat <= 22), 1);
        base = n_res;
        drain("bp_drain", 200);
        chk("bp_count", 32'(n_res - base), 2);

        // Reset in the middle of a pass.
        for (int i = 0; i < 20; i++) src.push_back(8'sd64);
        k = 0;
        while (corr_tim != 5'd7 && k < 80) begin step(); k++; end
        chk("mid_tim7", 32'(corr_tim), 7);
        rst = 1'b1;
        src.delete(); frame.delete(); exp_q.delete(); pk = 0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) src.push_back(8'sd64);
        base = n_res;
        drain("post_rst_drain", 100);
        chk("post_rst_count", 32'(n_res - base), 1);

        // Missing ready at the last phase: sticky error, no result, back to idle.
        suppress_rdy = 1'b1;
        push_frame_rand();
        run_until_acc(n_acc + 20, 40);
        k = 0;
        while (!busy && k < 5) begin step(); k++; end
        k = 0;
        while (busy && k < 40) begin step(); k++; end
        chk("perr_err", 32'(err), 1);
        chk("perr_res_valid", 32'(res_valid), 0);
        chk("perr_idle", 32'(busy), 0);
        chk("perr_tim", 32'(corr_tim), 31);
        chk("perr_pending", 32'(exp_q.size()), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        suppress_rdy = 1'b0;
        push_frame_rand();
        base = n_res;
        drain("perr_next_drain", 100);
        chk("perr_next_count", 32'(n_res - base), 1);
        chk("perr_sticky", 32'(err), 1);

`ifdef CORR_FRAME_SEQ_PEAK_EN
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        pk = 0;
        chk("peak_clr", 32'(peak_mag), 0);
`endif

        // Ready outside the last phase also flags an error.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("spur_pre_err", 32'(err), 0);
        spurious_rdy = 1'b1;
        step();
        spurious_rdy = 1'b0;
        chk("spur_err", 32'(err), 1);
        chk("spur_res_valid", 32'(res_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
